// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver, LSB first, fixed baud set by CLKS_PER_BIT. The serial
// line passes through a two-flop synchroniser, and the receive FSM only
// ever looks at the second stage (rx_s). Each good byte is presented on
// Rx_Byte with a single-cycle Rx_DV strobe. A stop bit that samples low
// gives a single-cycle Rx_Frame_Err strobe. The receiver then waits in
// BREAK until the line returns high, so a line held low is not decoded as
// a stream of 0x00 frames. A start bit that is no longer low at its
// midpoint is treated as a glitch and dropped without any strobe.
//
// Ports:
//   Clock        in   system clock, all logic on the rising edge
//   Reset_n      in   synchronous, active-low reset
//   Rx_Serial    in   asynchronous serial line, idle high
//   Rx_DV        out  one-cycle pulse: Rx_Byte holds a new good byte
//   Rx_Byte      out  last good byte, held until the next good byte
//   Rx_Frame_Err out  one-cycle pulse: stop bit sampled low
//   Rx_Busy      out  high while the FSM is anywhere other than IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Rx_Serial,
  output logic       Rx_DV,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Frame_Err,
  output logic       Rx_Busy
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP,
    BREAK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic [7:0]       byte_next;
  logic             dv_next;
  logic             fe_next;
  logic             rx_meta;
  logic             rx_s;

  // Two-flop synchroniser for the asynchronous serial line. Both stages
  // reset to the idle (high) level, so leaving reset never looks like a
  // start edge.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  // State register plus the registered outputs. The strobes are registered
  // copies of dv_next / fe_next. They are therefore high for exactly the one
  // cycle after the stop-bit sample, and cannot overlap because only one of
  // them is ever set at that sample.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      Rx_Byte      <= '0;
      Rx_DV        <= 1'b0;
      Rx_Frame_Err <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      bit_idx      <= bit_idx_next;
      shift        <= shift_next;
      Rx_Byte      <= byte_next;
      Rx_DV        <= dv_next;
      Rx_Frame_Err <= fe_next;
    end
  end

  // Next-state logic. Timing is referenced to t0, the cycle in which IDLE
  // sees rx_s low. The counter is loaded with 1 on leaving IDLE so that t0
  // itself is counted. As a result, the start-bit midpoint check at
  // cnt == HALF_BIT falls exactly at t0 + HALF_BIT. Each data/stop sample
  // then lands a whole bit period (cnt == CLKS_PER_BIT-1) later. The
  // counter is cleared at every sample point and so never exceeds
  // CLKS_PER_BIT-1.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    byte_next    = Rx_Byte;
    dv_next      = 1'b0;
    fe_next      = 1'b0;

    case (state)
      IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (!rx_s) begin
          state_next = START;
          cnt_next   = CNT_W'(1);
        end
      end

      START: begin
        if (cnt == HALF_CNT) begin
          cnt_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_next = '0;
          if (rx_s) begin
            byte_next  = shift;
            dv_next    = 1'b1;
            state_next = CLEANUP;
          end else begin
            fe_next    = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      // A single cycle that lets the strobe drop. A start edge arriving now
      // is not lost, because IDLE re-examines rx_s on the very next cycle.
      CLEANUP: begin
        state_next = IDLE;
      end

      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Busy covers every non-idle state, including the CLEANUP cycle in which
  // the strobe is visible.
  assign Rx_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx with CLKS_PER_BIT = 16. A timestamp-based
// reference model follows the line as a receiver would. It works from the
// start time t0, the midpoint offset and whole-bit offsets. Its outputs are
// compared with the DUT on every cycle. Hand-computed latencies and byte
// values for each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;

  localparam int M_IDLE  = 0;
  localparam int M_RX    = 1;
  localparam int M_CLEAN = 2;
  localparam int M_BREAK = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic ser_at_edge = 1'b1;
  logic rst_at_edge = 1'b0;

  int       m_mode = M_IDLE;
  int       m_t0   = 0;
  bit [7:0] m_data = '0;
  bit       m_d1   = 1'b1;
  bit       m_d2   = 1'b1;
  bit       exp_dv;
  bit       exp_fe;
  bit       exp_busy;
  bit [7:0] exp_byte = '0;

  int       dv_count   = 0;
  int       fe_count   = 0;
  int       busy_rises = 0;
  int       last_busy_rise = 0;
  int       last_busy_fall = 0;
  logic     prev_busy = 1'b0;
  int       dv_cyc_q[$];
  int       dv_byte_q[$];
  int       fe_cyc_q[$];
  int       fe_byte_q[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .Clock       (clk),
    .Reset_n     (reset_n),
    .Rx_Serial   (rx_serial),
    .Rx_DV       (rx_dv),
    .Rx_Byte     (rx_byte),
    .Rx_Frame_Err(rx_frame_err),
    .Rx_Busy     (rx_busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Edge counter plus a copy of the inputs exactly as the DUT saw them at
  // each rising edge, for the model to consume half a cycle later.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    ser_at_edge <= rx_serial;
    rst_at_edge <= reset_n;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc,
               actual, expected);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Sends one 8N1 frame starting just after the current edge, one bit per C
  // edges. If rst_at >= 0, Reset_n is pulsed low for the edge with that
  // offset and the transmitter abandons the rest of the frame (line idle).
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int rst_at);
    logic aborted = 1'b0;
    logic v;
    int   b;
    for (int n = 0; n < 10 * C; n++) begin
      b = n / C;
      if (b == 0) v = 1'b0;
      else if (b == 9) v = stop_bit;
      else v = data[b-1];
      if (n == rst_at) begin
        aborted   = 1'b1;
        reset_n   = 1'b0;
        rx_serial = 1'b1;
        #1;
        checkOutput("busy_held_until_reset_edge", 32'(rx_busy), 32'd1);
      end else begin
        reset_n   = 1'b1;
        rx_serial = aborted ? 1'b1 : v;
      end
      wait_edge();
      if (n == rst_at) begin
        checkOutput("midreset_dv", 32'(rx_dv), 32'd0);
        checkOutput("midreset_fe", 32'(rx_frame_err), 32'd0);
        checkOutput("midreset_busy", 32'(rx_busy), 32'd0);
        checkOutput("midreset_byte", 32'(rx_byte), 32'd0);
      end
    end
    reset_n = 1'b1;
  endtask

  // Reference model and per-cycle compare. The model processes the edge
  // just passed: the synchroniser makes the receiver see the line two edges
  // late. Sampling points are derived arithmetically from t0: the start
  // check at t0+H, then data bits and the stop bit at t0+H+k*C.
  initial begin : compare_proc
    bit line;
    int k;
    int idx;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        line   = m_d2;
        exp_dv = 1'b0;
        exp_fe = 1'b0;
        if (!rst_at_edge) begin
          m_mode   = M_IDLE;
          exp_byte = '0;
          m_d1     = 1'b1;
          m_d2     = 1'b1;
        end else begin
          case (m_mode)
            M_IDLE: begin
              if (!line) begin
                m_mode = M_RX;
                m_t0   = cyc;
              end
            end
            M_RX: begin
              k = cyc - m_t0;
              if (k == H) begin
                if (line) m_mode = M_IDLE;
              end else if (k > H && ((k - H) % C) == 0) begin
                idx = (k - H) / C;
                if (idx <= 8) begin
                  m_data[idx-1] = line;
                end else if (line) begin
                  exp_byte = m_data;
                  exp_dv   = 1'b1;
                  m_mode   = M_CLEAN;
                end else begin
                  exp_fe = 1'b1;
                  m_mode = M_BREAK;
                end
              end
            end
            M_CLEAN: m_mode = M_IDLE;
            default: if (line) m_mode = M_IDLE;
          endcase
          m_d2 = m_d1;
          m_d1 = ser_at_edge;
        end
        exp_busy = (m_mode != M_IDLE);

        checkOutput("model_rx_dv", 32'(rx_dv), 32'(exp_dv));
        checkOutput("model_rx_frame_err", 32'(rx_frame_err), 32'(exp_fe));
        checkOutput("model_rx_busy", 32'(rx_busy), 32'(exp_busy));
        checkOutput("model_rx_byte", 32'(rx_byte), 32'(exp_byte));

        if (rx_dv === 1'b1) begin
          dv_count++;
          dv_cyc_q.push_back(cyc);
          dv_byte_q.push_back(int'(rx_byte));
        end
        if (rx_frame_err === 1'b1) begin
          fe_count++;
          fe_cyc_q.push_back(cyc);
          fe_byte_q.push_back(int'(rx_byte));
        end
        if (rx_busy === 1'b1 && prev_busy !== 1'b1) begin
          busy_rises++;
          last_busy_rise = cyc;
        end
        if (rx_busy === 1'b0 && prev_busy === 1'b1) begin
          last_busy_fall = cyc;
        end
        prev_busy = rx_busy;
      end
    end
  end

  // Directed scenarios. Drive times are taken right after an edge (d = cyc);
  // the first edge to see the start bit is d+1, the receiver sees it at
  // t0 = d+3, and the stop sample is at t0+H+9C = d+154.
  initial begin : stim_proc
    int d;
    int ndv;
    int nfe;
    int nbr;

    reset_n   = 1'b0;
    rx_serial = 1'b1;

    $display("[TB] synchronous reset with toggling line");
    for (int i = 0; i < 8; i++) begin
      rx_serial = i[0];
      wait_edge();
      checkOutput("reset_dv", 32'(rx_dv), 32'd0);
      checkOutput("reset_fe", 32'(rx_frame_err), 32'd0);
      checkOutput("reset_busy", 32'(rx_busy), 32'd0);
      checkOutput("reset_byte", 32'(rx_byte), 32'd0);
    end
    rx_serial = 1'b1;
    reset_n   = 1'b1;
    repeat (10) wait_edge();
    checkOutput("idle_after_reset_busy", 32'(rx_busy), 32'd0);

    $display("[TB] single frame 0xA5");
    ndv = dv_count;
    nfe = fe_count;
    d   = cyc;
    applyStimulus(8'hA5, 1'b1, -1);
    repeat (20) wait_edge();
    checkOutput("a5_dv_count", 32'(dv_count - ndv), 32'd1);
    checkOutput("a5_fe_count", 32'(fe_count - nfe), 32'd0);
    if (dv_count - ndv == 1) begin
      checkOutput("a5_dv_latency", 32'(dv_cyc_q[ndv] - d), 32'd154);
      checkOutput("a5_byte", 32'(dv_byte_q[ndv]), 32'h0000_00A5);
    end
    checkOutput("a5_busy_rise", 32'(last_busy_rise - d), 32'd3);
    checkOutput("a5_busy_fall", 32'(last_busy_fall - d), 32'd155);

    $display("[TB] back-to-back frames 0x00 0xFF 0x3C");
    ndv = dv_count;
    d   = cyc;
    applyStimulus(8'h00, 1'b1, -1);
    applyStimulus(8'hFF, 1'b1, -1);
    applyStimulus(8'h3C, 1'b1, -1);
    repeat (20) wait_edge();
    checkOutput("b2b_dv_count", 32'(dv_count - ndv), 32'd3);
    if (dv_count - ndv == 3) begin
      checkOutput("b2b_first_latency", 32'(dv_cyc_q[ndv] - d), 32'd154);
      checkOutput("b2b_spacing_1", 32'(dv_cyc_q[ndv+1] - dv_cyc_q[ndv]), 32'd160);
      checkOutput("b2b_spacing_2", 32'(dv_cyc_q[ndv+2] - dv_cyc_q[ndv+1]), 32'd160);
      checkOutput("b2b_byte_0", 32'(dv_byte_q[ndv]), 32'h0000_0000);
      checkOutput("b2b_byte_1", 32'(dv_byte_q[ndv+1]), 32'h0000_00FF);
      checkOutput("b2b_byte_2", 32'(dv_byte_q[ndv+2]), 32'h0000_003C);
    end

    $display("[TB] 4-cycle glitch");
    ndv = dv_count;
    nfe = fe_count;
    nbr = busy_rises;
    rx_serial = 1'b0;
    repeat (4) wait_edge();
    rx_serial = 1'b1;
    repeat (40) wait_edge();
    checkOutput("glitch_dv_count", 32'(dv_count - ndv), 32'd0);
    checkOutput("glitch_fe_count", 32'(fe_count - nfe), 32'd0);
    checkOutput("glitch_busy_pulses", 32'(busy_rises - nbr), 32'd1);
    checkOutput("glitch_busy_width", 32'(last_busy_fall - last_busy_rise), 32'(H));
    checkOutput("glitch_busy_clear", 32'(rx_busy), 32'd0);

    $display("[TB] frame 0x81 with low stop bit, then break");
    ndv = dv_count;
    nfe = fe_count;
    d   = cyc;
    applyStimulus(8'h81, 1'b0, -1);
    rx_serial = 1'b0;
    repeat (40) wait_edge();
    checkOutput("break_busy_held", 32'(rx_busy), 32'd1);
    checkOutput("break_fe_count", 32'(fe_count - nfe), 32'd1);
    checkOutput("break_dv_count", 32'(dv_count - ndv), 32'd0);
    if (fe_count - nfe == 1) begin
      checkOutput("break_fe_latency", 32'(fe_cyc_q[nfe] - d), 32'd154);
      checkOutput("break_byte_at_fe", 32'(fe_byte_q[nfe]), 32'h0000_003C);
    end
    checkOutput("break_byte_kept", 32'(rx_byte), 32'h0000_003C);
    rx_serial = 1'b1;
    repeat (20) wait_edge();
    checkOutput("break_released_busy", 32'(rx_busy), 32'd0);
    ndv = dv_count;
    applyStimulus(8'h55, 1'b1, -1);
    repeat (20) wait_edge();
    checkOutput("after_break_dv_count", 32'(dv_count - ndv), 32'd1);
    checkOutput("after_break_byte", 32'(rx_byte), 32'h0000_0055);

    $display("[TB] reset at bit-4 midpoint of 0x5A, then 0xC3");
    ndv = dv_count;
    nfe = fe_count;
    applyStimulus(8'h5A, 1'b1, 89);
    repeat (20) wait_edge();
    checkOutput("midreset_no_dv", 32'(dv_count - ndv), 32'd0);
    checkOutput("midreset_no_fe", 32'(fe_count - nfe), 32'd0);
    checkOutput("midreset_byte_cleared", 32'(rx_byte), 32'd0);
    d = cyc;
    applyStimulus(8'hC3, 1'b1, -1);
    repeat (20) wait_edge();
    checkOutput("c3_dv_count", 32'(dv_count - ndv), 32'd1);
    if (dv_count - ndv == 1) begin
      checkOutput("c3_dv_latency", 32'(dv_cyc_q[ndv] - d), 32'd154);
      checkOutput("c3_byte", 32'(dv_byte_q[ndv]), 32'h0000_00C3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
